// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types and width helpers for the round-robin hold arbiter.
package arb_pkg;

    localparam int MAX_N_REQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // gnt_id needs room for "none" plus one code per requester.
    function automatic int id_width(input int n_req);
        return $clog2(n_req + 1);
    endfunction

    function automatic int idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr, skipping the masked owner.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int IW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic [N_REQ-1:0] mask_owner,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] rot;
    logic             found;

    // ptr is always < N_REQ, so one conditional subtract is a full modulo.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IW'(s);
    endfunction

    always_comb begin
        cand  = req & ~mask_owner;
        rot   = '0;
        valid = 1'b0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = cand[wrap_add(ptr, i)];
        end
        valid = |rot;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter; the owner keeps the grant while requesting,
// but yields after MAX_HOLD cycles whenever someone else is waiting.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           gnt,
    output logic [id_width(N_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int IW = idx_width(N_REQ);
    localparam int GW = id_width(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e       state;
    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;

    logic [N_REQ-1:0] mask_owner;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic             owner_req;
    logic             hold_full;
    logic             take;
    logic             release_gnt;
    logic [GW-1:0]    enc_id;

    // ptr already sits at owner+1 during a grant, so masking the owner makes
    // the same scan serve IDLE pick, preemption and handoff.
    assign mask_owner = (state == GRANT) ? gnt : '0;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .ptr        (ptr),
        .mask_owner (mask_owner),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign owner_req = |(req & gnt);
    assign hold_full = (hold_cnt == HW'(MAX_HOLD));

    always_comb begin
        take        = 1'b0;
        release_gnt = 1'b0;
        if (state == IDLE) begin
            take = pick_valid;
        end else if (owner_req) begin
            take = pick_valid && hold_full;
        end else begin
            take        = pick_valid;
            release_gnt = !pick_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
        end else if (take) begin
            state    <= GRANT;
            ptr      <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            hold_cnt <= HW'(1);
            gnt      <= N_REQ'(1) << pick_idx;
            gnt_id   <= GW'(pick_idx) + GW'(1);
            busy     <= 1'b1;
        end else if (release_gnt) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
        end else if (state == GRANT && !hold_full) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Independent decode of gnt used only to cross-check the registered id.
    always_comb begin
        enc_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                enc_id = GW'(i + 1);
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_id_zero: assert property (@(posedge clk) disable iff (!rst_n) (gnt_id == '0) == (gnt == '0));
    a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));
    a_encode: assert property (@(posedge clk) disable iff (!rst_n) gnt_id == enc_id);

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomized scoreboard bench for rr_hold_arbiter against a rule-level reference model.
module tb_rr_hold_arbiter;

    localparam int N     = 3;
    localparam int MH    = 4;
    localparam int GW    = 2;
    localparam int W     = 1 + GW + N;
    localparam int BOUND = (N - 1) * MH + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [GW-1:0] gnt_id;
    logic          busy;

    logic [W-1:0]  exp_q[$];
    int            checks = 0;
    int            failures = 0;

    // Reference model state: owner index (-1 = none), consecutive grant count, scan start.
    int            m_own = -1;
    int            m_cnt = 0;
    int            m_ptr = 0;
    int            wait_c[N];
    bit            served[N];

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    function automatic int m_pick(input logic [N-1:0] r, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (j != skip && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int prev;
        int o;
        logic [N-1:0]  e_gnt;
        logic [GW-1:0] e_id;
        prev = m_own;
        if (m_own < 0) begin
            o = m_pick(r, m_ptr, -1);
            if (o >= 0) begin
                m_own = o;
                m_cnt = 1;
            end
        end else if (r[m_own]) begin
            o = m_pick(r, m_own + 1, m_own);
            if (o >= 0 && m_cnt == MH) begin
                m_own = o;
                m_cnt = 1;
            end else if (m_cnt < MH) begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            o = m_pick(r, m_own + 1, m_own);
            if (o >= 0) begin
                m_own = o;
                m_cnt = 1;
            end else begin
                m_own = -1;
                m_cnt = 0;
            end
        end
        if (m_own >= 0 && m_own != prev) m_ptr = (m_own + 1) % N;

        for (int i = 0; i < N; i++) begin
            if (m_own == i && prev != i) begin
                checks++;
                if (wait_c[i] > BOUND) begin
                    failures++;
                    $display("FAIL wait_bound req%0d waited=%0d limit=%0d", i, wait_c[i], BOUND);
                end
                wait_c[i] = 0;
                served[i] = 1'b1;
            end else if (r[i] && m_own != i) begin
                wait_c[i]++;
            end else if (!r[i]) begin
                wait_c[i] = 0;
            end
        end

        e_gnt = '0;
        e_id  = '0;
        if (m_own >= 0) begin
            e_gnt[m_own] = 1'b1;
            e_id = GW'(m_own + 1);
        end
        exp_q.push_back({(m_own >= 0), e_id, e_gnt});
    endtask

    task automatic step(input logic [N-1:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({busy, gnt_id, gnt} !== '0) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, {busy, gnt_id, gnt}, {W{1'b0}});
        end
    endtask

    // Async reset in the middle of a cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_cleared("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({busy, gnt_id, gnt} !== e) begin
                    failures++;
                    $display("FAIL grant t=%0t got busy/id/gnt=%b exp=%b", $time, {busy, gnt_id, gnt}, e);
                end
            end
        end
    end

    initial begin : driver
        logic [N-1:0] nr;
        rst_n = 1'b1;
        req   = '0;
        for (int i = 0; i < N; i++) served[i] = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_cleared("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        step(3'b001);
        step(3'b000);
        step(3'b000);

        for (int i = 0; i < 14; i++) step(3'b111);
        step(3'b000);

        async_reset();
        step(3'b001);
        for (int i = 0; i < 6; i++) step(3'b011);
        for (int i = 0; i < 3; i++) step(3'b001);
        step(3'b000);

        for (int i = 0; i < 20; i++) step(3'b100);
        step(3'b000);

        step(3'b010);
        step(3'b010);
        async_reset();
        step(3'b110);
        step(3'b110);
        step(3'b000);
        step(3'b000);

        nr = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!nr[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        nr[i] = 1'b1;
                        served[i] = 1'b0;
                    end
                end else if (served[i] && $urandom_range(0, 3) == 0) begin
                    nr[i] = 1'b0;
                end
            end
            step(nr);
        end
        step(3'b000);
        step(3'b000);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
